instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage: issues word fetches to instruction memory, pairs each returned word with its PC, and presents {pc, ir} to the downstream pipeline buffer over a valid/ready handshake. A one-entry skid slot absorbs a response that arrives while the output is stalled. Branch redirects flush in-flight and buffered instructions. It is the first stage of the core pipeline and feeds the fetch/decode pipeline buffer.

## Interface
- BOOT_ADDR, 32'h0000_0000, first fetch address after reset (word aligned)
- clk  in  1  clock
- rstz  in  1  asynchronous active-low reset
- instr_addr  out  32  fetch address, registered
- instr_req  out  1  fetch request, registered
- instr_ack  in  1  memory accepts request; instr_data valid the same cycle
- instr_data  in  32  fetched word
- branch  in  1  redirect strobe, single cycle
- branch_target  in  32  redirect address; bits [1:0] ignored (taken as 0)
- pc  out  32  address of ir
- ir  out  32  instruction word
- fetch_vld  out  1  {pc, ir} valid
- fetch_rdy  in  1  downstream accepts {pc, ir}

## Operation
- Transaction completes when instr_req && instr_ack. Once raised, instr_req and instr_addr hold until ack.
- Output slot (pc/ir/fetch_vld) is free when ~fetch_vld | fetch_rdy. Skid slot holds one {pc, word}.
- The FSM has four states:
  - RESET: one cycle after rstz deasserts, then go to FETCH.
  - FETCH: instr_req = 1.
    - On ack with no branch and a free output slot: load the output with {instr_addr, instr_data}, set instr_addr += 4, stay in FETCH.
    - On ack with no branch and the output occupied and not dequeued: load the skid slot, set instr_addr += 4, deassert instr_req, go to STALL.
  - STALL: instr_req = 0. When fetch_rdy: move skid to output, clear skid, go to FETCH.
  - FLUSH: instr_req is held with the old address. On ack: discard data, set instr_addr = stored target, go to FETCH.
- Branch rules. Branch has priority over all other events.
  - On every branch: the output is cleared (fetch_vld = 0 next cycle) and the skid slot is cleared.
  - In FETCH with ack the same cycle: discard data, set instr_addr = target, stay in FETCH.
  - In FETCH without ack: store the target, go to FLUSH.
  - In STALL: set instr_addr = target, go to FETCH.
  - In FLUSH: overwrite the stored target.
  - In RESET: set instr_addr = target.
- A downstream dequeue in a branch cycle is legal. The dequeued instruction counts as consumed.
- instr_addr increments modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0.

## Timing
- Reset values:
  - instr_req = 0, instr_addr = BOOT_ADDR
  - pc = BOOT_ADDR, ir = 32'h0000_0013 (NOP)
  - fetch_vld = 0, skid empty, state RESET
- First instr_req = 1 on the second rising edge after rstz deasserts.
- Latency: ack in cycle N gives fetch_vld = 1 with that word in cycle N+1.
- Throughput: one instruction per cycle with a same-cycle-ack memory and fetch_rdy held high.
- STALL exit: fetch_rdy in cycle N gives the skid word on the output in N+1, and instr_req = 1 in N+1.
- Branch in cycle N with ack:
  - instr_req = 1 with instr_addr = target in N+1.
  - Target word appears on the output no earlier than N+2.
- Reset asserted mid-transaction: all state returns to reset values immediately. The pending memory response is not tracked.
- pc, ir and fetch_vld change only on enqueue, dequeue or flush. They are stable while fetch_vld && ~fetch_rdy.

## Structure
- Shared package, to be added to the core package:
  - fetch_state_e typedef with RESET, FETCH, STALL, FLUSH
  - NOP constant 32'h0000_0013
  - INSTR_STEP constant 4
- No sub-module. The skid slot is two registers plus a valid bit held inline; the output register is the stage's own.

## Test plan
- Reset release with BOOT_ADDR = 32'h100, memory acks every cycle, fetch_rdy = 1:
  - instr_req first high on cycle 2.
  - Outputs pc = 32'h100, 104, 108 on consecutive cycles, fetch_vld continuously 1.
- Backpressure:
  - Hold fetch_rdy = 0 after the first word: one word goes to skid and instr_req drops. There is no further ack.
  - Release fetch_rdy: pc 32'h100, 104, 108 appear in order with none lost or duplicated.
- Branch in FETCH with ack, target 32'h2000: the next request address is 32'h2000, and the first valid pc after the flush is 32'h2000.
- Branch with ack delayed 3 cycles (FLUSH), target 32'h40, then a second branch to 32'h80 while in FLUSH:
  - The old request is held until ack and its data is dropped.
  - The next request address is 32'h80.
- Wrap: instr_addr = 32'hFFFF_FFFC acks, then the next request address is 32'h0000_0000.
- Reset asserted while in STALL with skid full: next cycle fetch_vld = 0, instr_req = 0, pc = BOOT_ADDR, ir = NOP.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// NOP word, PC step and a word-alignment helper.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] INSTR_STEP = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch stage bus bundle: instruction memory port, branch redirect and the
// {pc, ir} valid/ready output toward the decode buffer.
interface instr_fetch_if;

  logic [31:0] instr_addr;
  logic        instr_req;
  logic        instr_ack;
  logic [31:0] instr_data;
  logic        branch;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        fetch_vld;
  logic        fetch_rdy;

  // The fetch stage itself drives memory requests and the pipeline output.
  modport master (
    output instr_addr, instr_req, pc, ir, fetch_vld,
    input  instr_ack, instr_data, branch, branch_target, fetch_rdy
  );

  modport slave (
    input  instr_addr, instr_req, pc, ir, fetch_vld,
    output instr_ack, instr_data, branch, branch_target, fetch_rdy
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: word fetches from instruction memory, one-entry
// skid slot behind the {pc, ir} output register, branch redirect and flush.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rstz,
  instr_fetch_if.master bus
);

  fetch_state_e state_q;
  logic         boot_wait_q;
  logic [31:0]  addr_q;
  logic         req_q;
  logic [31:0]  target_q;
  logic [31:0]  pc_q;
  logic [31:0]  ir_q;
  logic         vld_q;
  logic [31:0]  skid_pc_q;
  logic [31:0]  skid_ir_q;
  logic         skid_vld_q;

  logic         ack_s;
  logic         deq_s;
  logic         out_free_s;
  logic [31:0]  tgt_s;
  logic [31:0]  next_addr_s;

  assign ack_s       = req_q & bus.instr_ack;
  assign deq_s       = vld_q & bus.fetch_rdy;
  assign out_free_s  = ~vld_q | bus.fetch_rdy;
  assign tgt_s       = align_word(bus.branch_target);
  assign next_addr_s = addr_q + INSTR_STEP;

  assign bus.instr_addr = addr_q;
  assign bus.instr_req  = req_q;
  assign bus.pc         = pc_q;
  assign bus.ir         = ir_q;
  assign bus.fetch_vld  = vld_q;

  // Fetch FSM with all registered outputs, output register and skid slot.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q     <= RESET;
      boot_wait_q <= 1'b1;
      addr_q      <= BOOT_ADDR;
      req_q       <= 1'b0;
      target_q    <= BOOT_ADDR;
      pc_q        <= BOOT_ADDR;
      ir_q        <= NOP;
      vld_q       <= 1'b0;
      skid_pc_q   <= BOOT_ADDR;
      skid_ir_q   <= NOP;
      skid_vld_q  <= 1'b0;
    end else begin
      // A branch kills everything buffered; otherwise a dequeue empties the
      // output unless an enqueue below refills it in the same cycle.
      if (bus.branch) begin
        vld_q      <= 1'b0;
        skid_vld_q <= 1'b0;
      end else if (deq_s) begin
        vld_q <= 1'b0;
      end

      case (state_q)
        RESET: begin
          if (bus.branch) begin
            addr_q <= tgt_s;
          end
          // Hold one extra cycle so the first request rises on the second
          // edge after reset release.
          if (boot_wait_q) begin
            boot_wait_q <= 1'b0;
          end else begin
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        end

        FETCH: begin
          if (bus.branch) begin
            if (ack_s) begin
              addr_q <= tgt_s;
            end else begin
              target_q <= tgt_s;
              state_q  <= FLUSH;
            end
          end else if (ack_s) begin
            addr_q <= next_addr_s;
            if (out_free_s) begin
              pc_q  <= addr_q;
              ir_q  <= bus.instr_data;
              vld_q <= 1'b1;
            end else begin
              skid_pc_q  <= addr_q;
              skid_ir_q  <= bus.instr_data;
              skid_vld_q <= 1'b1;
              req_q      <= 1'b0;
              state_q    <= STALL;
            end
          end
        end

        STALL: begin
          if (bus.branch) begin
            addr_q  <= tgt_s;
            req_q   <= 1'b1;
            state_q <= FETCH;
          end else if (bus.fetch_rdy) begin
            pc_q       <= skid_pc_q;
            ir_q       <= skid_ir_q;
            vld_q      <= 1'b1;
            skid_vld_q <= 1'b0;
            req_q      <= 1'b1;
            state_q    <= FETCH;
          end
        end

        FLUSH: begin
          // The outstanding request must complete before redirecting; its
          // data is dropped. A branch landing with the ack wins.
          if (ack_s) begin
            addr_q  <= bus.branch ? tgt_s : target_q;
            state_q <= FETCH;
          end else if (bus.branch) begin
            target_q <= tgt_s;
          end
        end

        default: begin
          state_q <= RESET;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed, table-driven bench for instr_fetch with a combinational
// same-cycle-ack instruction memory model.
module tb_instr_fetch;

  localparam logic [31:0] BOOT  = 32'h0000_0100;
  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic clk;
  logic rstz;
  logic ack_en;

  instr_fetch_if bus ();

  instr_fetch #(.BOOT_ADDR(BOOT)) dut (
    .clk  (clk),
    .rstz (rstz),
    .bus  (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign bus.instr_ack  = ack_en;
  assign bus.instr_data = mem_word(bus.instr_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        ack;
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   failures;

  function automatic vec_t mk(input logic rst_n, input logic ack, input logic rdy,
                              input logic br, input logic [31:0] tgt,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_vld, input logic [31:0] e_pc);
    vec_t v;
    v.rst_n = rst_n; v.ack = ack; v.rdy = rdy; v.br = br; v.tgt = tgt;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input int idx);
    check("rst_req",  idx, {31'd0, bus.instr_req}, 32'd0);
    check("rst_addr", idx, bus.instr_addr, BOOT);
    check("rst_vld",  idx, {31'd0, bus.fetch_vld}, 32'd0);
    check("rst_pc",   idx, bus.pc, BOOT);
    check("rst_ir",   idx, bus.ir, NOP_W);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstz     = 1'b0;
    ack_en   = 1'b0;
    bus.fetch_rdy     = 1'b0;
    bus.branch        = 1'b0;
    bus.branch_target = 32'd0;

    // Boot and streaming at one instruction per cycle
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h100, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h104, 1'b1, 32'h100));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h108, 1'b1, 32'h104));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10C, 1'b1, 32'h108));
    // Fresh reset, then backpressure into the skid slot
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h100, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h100, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h104, 1'b1, 32'h100));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h108, 1'b1, 32'h100));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h108, 1'b1, 32'h100));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h108, 1'b1, 32'h104));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10C, 1'b1, 32'h108));
    // Branch with ack (low target bits ignored), dequeue in the same cycle
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h2003, 1'b1, 32'h2000, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h2004, 1'b1, 32'h2000));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h2004, 1'b0, 32'h0));
    // Branch without ack -> FLUSH, second branch overrides target
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h2004, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h2004, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h2004, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h84, 1'b1, 32'h80));
    // Address wrap at the top of the space
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4, 1'b1, 32'h0));
    // Branch while stalled drops the skid word
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h8, 1'b1, 32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h304, 1'b1, 32'h300));

    repeat (2) @(posedge clk);
    #1;
    check_reset_vals(-1);

    for (int i = 0; i < vecs.size(); i++) begin
      rstz              = vecs[i].rst_n;
      ack_en            = vecs[i].ack;
      bus.fetch_rdy     = vecs[i].rdy;
      bus.branch        = vecs[i].br;
      bus.branch_target = vecs[i].tgt;
      step();
      check("req",  i, {31'd0, bus.instr_req}, {31'd0, vecs[i].e_req});
      check("addr", i, bus.instr_addr, vecs[i].e_addr);
      check("vld",  i, {31'd0, bus.fetch_vld}, {31'd0, vecs[i].e_vld});
      if (vecs[i].e_vld) begin
        check("pc", i, bus.pc, vecs[i].e_pc);
        check("ir", i, bus.ir, mem_word(vecs[i].e_pc));
      end
    end

    // Fill the skid slot, then assert reset while stalled
    ack_en        = 1'b1;
    bus.fetch_rdy = 1'b0;
    bus.branch    = 1'b0;
    step();
    check("stall_req",  100, {31'd0, bus.instr_req}, 32'd0);
    check("stall_addr", 100, bus.instr_addr, 32'h308);
    check("stall_pc",   100, bus.pc, 32'h300);
    rstz = 1'b0;
    #1;
    check_reset_vals(101);
    step();
    check_reset_vals(102);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
